// File: rtl/usb_uart_pkg.sv
// Shared types and elaboration helpers for the USB CDC UART receive path.
// Pure package: no latency, no backpressure.
package usb_uart_pkg;

  localparam int MIN_DIV = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_e;

  function automatic int calc_div(input int clk_freq, input int baudrate);
    return clk_freq / baudrate;
  endfunction

  function automatic bit div_legal(input int clk_freq, input int baudrate);
    return (baudrate > 0) && (clk_freq % baudrate == 0) && (clk_freq / baudrate >= MIN_DIV);
  endfunction

  function automatic bit depth_legal(input int depth);
    return (depth >= 2) && ((depth & (depth - 1)) == 0);
  endfunction

endpackage

// File: rtl/usb_uart_rx_fifo_if.sv
// Serial line in, buffered byte stream out with valid/accept and error pulses.
// Wires only: no latency; downstream stalls by holding accept_i low.
interface usb_uart_rx_fifo_if #(
  parameter int FIFO_DEPTH = 16
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic          rx_i;
  logic          accept_i;
  logic [7:0]    data_o;
  logic          valid_o;
  logic [LW-1:0] level_o;
  logic          frame_err_o;
  logic          overflow_o;

  modport master (
    input  rx_i, accept_i,
    output data_o, valid_o, level_o, frame_err_o, overflow_o
  );

  modport slave (
    output rx_i, accept_i,
    input  data_o, valid_o, level_o, frame_err_o, overflow_o
  );
endinterface

// File: rtl/usb_uart_sync_fifo.sv
// First-word fall-through FIFO; a write lands on data_out one edge later.
// Push into a full FIFO is refused unless a pop frees a slot in the same cycle.
module usb_uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       data_in,
  output logic                   full,
  input  logic                   pop,
  output logic [WIDTH-1:0]       data_out,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_pop;
  logic             do_push;

  assign level    = wr_ptr - rd_ptr;
  assign empty    = (level == '0);
  assign full     = (level == (AW+1)'(DEPTH));
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);
  assign data_out = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= data_in;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
    end
  end

endmodule

// File: rtl/usb_uart_rx_fifo.sv
// 8N1 receiver feeding a FWFT byte FIFO; byte visible one edge after its stop-bit tick.
// Full FIFO drops the new byte with an overflow pulse; accept_i pops when valid_o.
module usb_uart_rx_fifo
  import usb_uart_pkg::*;
#(
  parameter int CLK_FREQ   = 60000000,
  parameter int BAUDRATE   = 1000000,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  usb_uart_rx_fifo_if.master    bus
);
  localparam int DIV = calc_div(CLK_FREQ, BAUDRATE);
  localparam int CW  = $clog2(DIV);
  localparam int LW  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] HALF_LOAD = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(DIV - 1);

  if (!div_legal(CLK_FREQ, BAUDRATE)) begin : g_bad_div
    $error("usb_uart_rx_fifo: CLK_FREQ/BAUDRATE must be an integer >= 8");
  end
  if (!depth_legal(FIFO_DEPTH)) begin : g_bad_depth
    $error("usb_uart_rx_fifo: FIFO_DEPTH must be a power of two >= 2");
  end

  logic          rx_meta;
  logic          rx_s;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tick;
  logic          push;
  logic          frame_err_d;
  logic          overflow_d;
  logic          frame_err_q;
  logic          overflow_q;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic [LW-1:0] fifo_level;
  logic [7:0]    fifo_data;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx_i;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      frame_err_q <= frame_err_d;
      overflow_q  <= overflow_d;
    end
  end

  assign tick = (cnt_q == '0);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    push        = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          cnt_d   = HALF_LOAD;
          state_d = START;
        end
      end
      START: begin
        if (!tick) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rx_s) begin
          state_d = IDLE;
        end else begin
          cnt_d     = FULL_LOAD;
          bit_idx_d = '0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (!tick) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          cnt_d     = FULL_LOAD;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        if (!tick) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rx_s) begin
          push    = 1'b1;
          state_d = IDLE;
        end else begin
          frame_err_d = 1'b1;
          state_d     = BREAK;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop in the same cycle frees the slot, so only a full FIFO without pop refuses.
  assign pop        = !fifo_empty && bus.accept_i;
  assign overflow_d = push && fifo_full && !pop;

  usb_uart_sync_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk      (clk_i),
    .rst      (rst_i),
    .push     (push),
    .data_in  (shift_q),
    .full     (fifo_full),
    .pop      (pop),
    .data_out (fifo_data),
    .empty    (fifo_empty),
    .level    (fifo_level)
  );

  assign bus.data_o      = fifo_data;
  assign bus.valid_o     = !fifo_empty;
  assign bus.level_o     = fifo_level;
  assign bus.frame_err_o = frame_err_q;
  assign bus.overflow_o  = overflow_q;

endmodule

// File: tb/tb_usb_uart_rx_fifo.sv
// Drives 8N1 frames cycle by cycle and checks every cycle against a byte-queue model.
// The model applies pops before pushes at the edge that ends each frame's stop-bit tick.
module tb_usb_uart_rx_fifo;
  localparam int DIV    = 60;
  localparam int DEPTH  = 16;
  localparam int LW     = $clog2(DEPTH) + 1;
  localparam int PUSH_C = 2 + DIV / 2 + 9 * DIV;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  usb_uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

  usb_uart_rx_fifo #(
    .CLK_FREQ   (60000000),
    .BAUDRATE   (1000000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  byte unsigned model[$];
  bit   pend_fe  = 1'b0;
  bit   pend_ov  = 1'b0;
  bit   chk_en   = 1'b0;
  int   acc_mode = 0;
  int   fe_seen  = 0;
  int   ov_seen  = 0;
  logic [7:0] last_pop = 8'h00;

  // One clock cycle: check outputs, drive inputs, advance the model over the next edge.
  // evt: 0 none, 1 good byte completes at this edge, 2 bad stop bit at this edge.
  task automatic step(input logic rx_v, input logic rst_v, input int evt, input logic [7:0] b);
    logic exp_vld;
    @(negedge clk);
    if (chk_en) begin
      exp_vld = (model.size() != 0);
      total++;
      if (bus.level_o !== LW'(model.size())) begin
        bad++; $display("FAIL level: got %0d want %0d t=%0t", bus.level_o, model.size(), $time);
      end
      total++;
      if (bus.valid_o !== exp_vld) begin
        bad++; $display("FAIL valid: got %b want %b t=%0t", bus.valid_o, exp_vld, $time);
      end
      if (exp_vld) begin
        total++;
        if (bus.data_o !== model[0]) begin
          bad++; $display("FAIL data: got %02h want %02h t=%0t", bus.data_o, model[0], $time);
        end
      end
      total++;
      if (bus.frame_err_o !== pend_fe) begin
        bad++; $display("FAIL frame_err: got %b want %b t=%0t", bus.frame_err_o, pend_fe, $time);
      end
      total++;
      if (bus.overflow_o !== pend_ov) begin
        bad++; $display("FAIL overflow: got %b want %b t=%0t", bus.overflow_o, pend_ov, $time);
      end
      if (bus.frame_err_o === 1'b1) fe_seen++;
      if (bus.overflow_o === 1'b1) ov_seen++;
    end
    bus.rx_i = rx_v;
    rst = rst_v;
    case (acc_mode)
      0:       bus.accept_i = 1'b0;
      1:       bus.accept_i = 1'b1;
      2:       bus.accept_i = 1'($urandom_range(0, 1));
      default: bus.accept_i = (evt != 0);
    endcase
    pend_fe = 1'b0;
    pend_ov = 1'b0;
    if (rst_v) begin
      model.delete();
    end else begin
      if (model.size() != 0 && bus.accept_i) begin
        last_pop = bus.data_o;
        void'(model.pop_front());
      end
      if (evt == 1) begin
        if (model.size() < DEPTH) model.push_back(b);
        else pend_ov = 1'b1;
      end else if (evt == 2) begin
        pend_fe = 1'b1;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 8'h00);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int extra_low);
    logic bv;
    int   ev;
    for (int c = 0; c < 10 * DIV; c++) begin
      if (c < DIV) bv = 1'b0;
      else if (c < 9 * DIV) bv = b[c / DIV - 1];
      else bv = stop_ok;
      ev = (c == PUSH_C) ? (stop_ok ? 1 : 2) : 0;
      step(bv, 1'b0, ev, b);
    end
    for (int i = 0; i < extra_low; i++) step(1'b0, 1'b0, 0, 8'h00);
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 0, 8'h00);
    step(1'b1, 1'b0, 0, 8'h00);
  endtask

  task automatic test_reset();
    step(1'b1, 1'b1, 0, 8'h00);
    chk_en = 1'b1;
    step(1'b1, 1'b1, 0, 8'h00);
    step(1'b1, 1'b1, 0, 8'h00);
    total++;
    if (bus.data_o !== 8'h00) begin
      bad++; $display("FAIL reset_data: got %02h want 00", bus.data_o);
    end
    step(1'b1, 1'b0, 0, 8'h00);
  endtask

  task automatic test_byte_receive();
    acc_mode = 0;
    send_frame(8'hA5, 1'b1, 0);
    idle(4);
    total++;
    if (bus.data_o !== 8'hA5 || bus.level_o !== LW'(1)) begin
      bad++; $display("FAIL byte_rx: data %02h level %0d want a5 1", bus.data_o, bus.level_o);
    end
    acc_mode = 1;
    idle(3);
  endtask

  task automatic test_back_to_back();
    logic [7:0] pat [4];
    pat[0] = 8'h00; pat[1] = 8'hFF; pat[2] = 8'h55; pat[3] = 8'h81;
    acc_mode = 1;
    for (int i = 0; i < 4; i++) send_frame(pat[i], 1'b1, 0);
    idle(4);
    total++;
    if (bus.level_o !== '0 || last_pop !== 8'h81) begin
      bad++; $display("FAIL burst: level %0d last %02h want 0 81", bus.level_o, last_pop);
    end
  endtask

  task automatic test_overflow();
    int ov0;
    do_reset();
    acc_mode = 0;
    ov0 = ov_seen;
    for (int i = 0; i < 17; i++) send_frame(8'(8'h10 + i), 1'b1, 0);
    idle(3);
    total++;
    if (bus.level_o !== LW'(16) || bus.data_o !== 8'h10 || ov_seen - ov0 != 1) begin
      bad++; $display("FAIL overflow_case: level %0d head %02h pulses %0d want 16 10 1",
                      bus.level_o, bus.data_o, ov_seen - ov0);
    end
    acc_mode = 1;
    idle(20);
  endtask

  task automatic test_full_pop();
    int ov0;
    do_reset();
    acc_mode = 0;
    ov0 = ov_seen;
    for (int i = 0; i < 16; i++) send_frame(8'(8'h10 + i), 1'b1, 0);
    acc_mode = 3;
    send_frame(8'h20, 1'b1, 0);
    acc_mode = 0;
    idle(3);
    total++;
    if (bus.level_o !== LW'(16) || bus.data_o !== 8'h11 || ov_seen != ov0) begin
      bad++; $display("FAIL full_pop: level %0d head %02h pulses %0d want 16 11 0",
                      bus.level_o, bus.data_o, ov_seen - ov0);
    end
    acc_mode = 1;
    idle(20);
    total++;
    if (last_pop !== 8'h20) begin
      bad++; $display("FAIL full_pop_tail: got %02h want 20", last_pop);
    end
  endtask

  task automatic test_framing();
    int fe0;
    acc_mode = 1;
    fe0 = fe_seen;
    send_frame(8'h3C, 1'b0, 3 * DIV);
    idle(DIV);
    send_frame(8'h7E, 1'b1, 0);
    idle(4);
    total++;
    if (fe_seen - fe0 != 1 || last_pop !== 8'h7E) begin
      bad++; $display("FAIL framing: pulses %0d last %02h want 1 7e", fe_seen - fe0, last_pop);
    end
  endtask

  task automatic test_glitch_reset();
    acc_mode = 0;
    for (int i = 0; i < DIV / 4; i++) step(1'b0, 1'b0, 0, 8'h00);
    idle(2 * DIV);
    for (int c = 0; c < 4 * DIV; c++) step((c < DIV) ? 1'b0 : c[0], 1'b0, 0, 8'h00);
    do_reset();
    idle(12 * DIV);
    total++;
    if (bus.valid_o !== 1'b0) begin
      bad++; $display("FAIL glitch_reset: valid %b want 0", bus.valid_o);
    end
    send_frame(8'h42, 1'b1, 0);
    idle(3);
    total++;
    if (bus.data_o !== 8'h42 || bus.level_o !== LW'(1)) begin
      bad++; $display("FAIL after_reset: data %02h level %0d want 42 1", bus.data_o, bus.level_o);
    end
    acc_mode = 1;
    idle(3);
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit         ok;
    acc_mode = 2;
    for (int i = 0; i < 12; i++) begin
      b  = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      send_frame(b, ok, ok ? 0 : int'($urandom_range(0, DIV)));
      idle(ok ? int'($urandom_range(0, DIV / 2)) : DIV);
    end
    acc_mode = 1;
    idle(30);
    total++;
    if (bus.level_o !== '0) begin
      bad++; $display("FAIL random_drain: level %0d want 0", bus.level_o);
    end
  endtask

  initial begin
    bus.rx_i     = 1'b1;
    bus.accept_i = 1'b0;
    test_reset();
    test_byte_receive();
    test_back_to_back();
    test_overflow();
    test_full_pop();
    test_framing();
    test_glitch_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_uart_rx_fifo.md
Name: usb_uart_rx_fifo

Overview:
- Receives the 8N1 serial stream that the USB CDC bridge drives on its UART output (rx line, clocked from the 60 MHz ULPI clock domain).
- Converts that stream to bytes and buffers them in a FIFO.
- Presents bytes to downstream logic on a valid/accept handshake.
- Reports framing errors and FIFO overflow as single-cycle pulses.

Parameters:
- CLK_FREQ, 60000000, clk_i frequency in Hz.
- BAUDRATE, 1000000, serial bit rate. DIV = CLK_FREQ/BAUDRATE must be an integer ≥ 8; elaboration error otherwise.
- FIFO_DEPTH, 16, byte capacity. Power of two, ≥ 2.

Ports:
- clk_i  in  1  single clock; same clock as the USB core.
- rst_i  in  1  synchronous reset, active-high.
- rx_i  in  1  asynchronous serial input. Idle high, LSB first, 1 start, 8 data, 1 stop.
- data_o  out  8  head-of-FIFO byte; valid when valid_o=1.
- valid_o  out  1  FIFO non-empty.
- accept_i  in  1  pop request; takes effect only when valid_o=1.
- level_o  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- frame_err_o  out  1  one-cycle pulse; stop bit sampled low.
- overflow_o  out  1  one-cycle pulse; good byte dropped because FIFO full.

Behaviour:
- Reset (rst_i=1 at a clk_i edge):
  - valid_o=0, level_o=0, data_o=0, frame_err_o=0, overflow_o=0.
  - Synchroniser flops = 1, state = IDLE, counters = 0.
  - Reset mid-frame discards the partial byte. Reset also clears the FIFO contents.
- Synchroniser: rx_i passes through 2 flops to give rx_s. All decisions use rx_s only.
- Bit timer: down-counter cnt, width $clog2(DIV). A "tick" is a cycle with cnt==0.
- IDLE:
  - rx_s==0 → cnt=DIV/2-1, go START.
- START, on tick:
  - rx_s==1 → false start, go IDLE, no pulse.
  - rx_s==0 → cnt=DIV-1, bit_idx=0, go DATA.
- DATA:
  - On each tick: shift rx_s into shift[7] with shift right (LSB first), bit_idx+1, cnt=DIV-1.
  - After the 8th bit go STOP.
- STOP, on tick:
  - rx_s==1 → push shift into the FIFO, or pulse overflow_o if the push is refused. Go IDLE.
  - rx_s==0 → pulse frame_err_o, discard the byte, go BREAK.
- BREAK: stay until rx_s==1, then go IDLE. A held-low line never yields repeated frames.
- Sample points, relative to the first synchronised low cycle:
  - start bit at +DIV/2;
  - data bit n at +DIV/2 + (n+1)·DIV;
  - stop bit at +DIV/2 + 9·DIV.
- Latency: the push happens on the stop tick cycle. valid_o/data_o update on the next edge.
- FIFO:
  - First-word fall-through. Read/write pointers are $clog2(FIFO_DEPTH)+1 bits and wrap naturally.
  - Pop when valid_o && accept_i. accept_i while empty is ignored.
- Simultaneous push and pop:
  - Not full: level unchanged, both operations take effect.
  - Full: pop frees a slot, so the push is accepted and no overflow occurs.
  - Full, no pop: push refused, FIFO contents untouched, overflow_o pulses.
  - Empty: push accepted. The pop is ignored because valid_o=0 in that cycle. No bypass.
- frame_err_o and overflow_o are mutually exclusive. Each is high for exactly one cycle per event.

Decomposition:
- Package usb_uart_pkg:
  - state enum: IDLE, START, DATA, STOP, BREAK;
  - localparam helper for DIV and the parameter legality check.
- One sub-module: usb_uart_sync_fifo (parameter DEPTH, WIDTH). Interface: push/data_in/full, pop/data_out/empty, level. FWFT, synchronous reset.
- Receiver FSM, timer and synchroniser live in the top module.

Test Plan:
- Byte receive: DIV=60, send 0xA5 8N1, no accept → after stop tick (+DIV/2+9·DIV+3 cycles) valid_o=1, data_o=0xA5, level_o=1, no pulses.
- Burst and drain: send 0x00,0xFF,0x55,0x81 back-to-back, accept held high → bytes popped in order exactly once, level_o returns to 0.
- Overflow: FIFO_DEPTH=16, send 17 bytes 0x10..0x20, accept=0 → level_o=16, one overflow_o pulse on the 17th stop tick, head still 0x10.
- Full with pop: FIFO full, accept pulsed on the stop tick of byte 17 → no overflow, level_o stays 16, tail byte = 0x20.
- Framing error: send 0x3C with stop bit low, line held low 3·DIV → one frame_err_o pulse, no push. Line high then 0x7E → 0x7E received.
- Glitch and reset: low glitch of DIV/4 cycles → no frame, no pulse. rst_i asserted mid-data then released → no byte. Next 0x42 received correctly.
